// File: rtl/btn_debounce_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_pulser
//  Description : Push-button conditioner. Synchronizes a raw button input,
//                debounces press and release, and produces a clean level, a
//                single press pulse (scen) and an auto-repeat pulse train
//                (mcen).
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce_pulser #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int CNT_W           = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       db_level,
  output logic       scen,
  output logic       mcen,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE        = 3'b000,
    DEB_PRESS   = 3'b001,
    PRESS_PULSE = 3'b010,
    HOLD        = 3'b011,
    REPEAT      = 3'b100,
    DEB_RELEASE = 3'b101
  } state_t;

  localparam logic [CNT_W-1:0] C_DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  // The repeat count runs 0..REPEAT_CYCLES so that, like the first repeat
  // (terminal cycle plus the state change), repeats are REPEAT_CYCLES+1 apart.
  localparam logic [CNT_W-1:0] C_REP_LAST  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  logic             s1_q;
  logic             btn_s_q;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mcen_reg_q;
  logic             mcen_reg_d;

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      s1_q    <= btn_in;
      btn_s_q <= s1_q;
    end
  end

  // State, counter and repeat-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcen_reg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcen_reg_q <= mcen_reg_d;
    end
  end

  // Next-state, next-count and repeat-pulse request logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcen_reg_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn_s_q) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_DEB_LAST) begin
          state_d = PRESS_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      PRESS_PULSE: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        // Release wins over a coincident terminal count: no pulse.
        if (!btn_s_q) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == C_HOLD_LAST) begin
          state_d    = REPEAT;
          cnt_d      = '0;
          mcen_reg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      REPEAT: begin
        if (!btn_s_q) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == C_REP_LAST) begin
          cnt_d      = '0;
          mcen_reg_d = 1'b1;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      DEB_RELEASE: begin
        // A bounce back to pressed restarts the hold delay without a new press.
        if (btn_s_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == C_DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are pure decodes of registers, so they are glitch-free.
  assign scen     = (state_q == PRESS_PULSE);
  assign mcen     = (state_q == PRESS_PULSE) | mcen_reg_q;
  assign db_level = (state_q == PRESS_PULSE) | (state_q == HOLD) |
                    (state_q == REPEAT)      | (state_q == DEB_RELEASE);
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce_pulser
//  Description : Self-checking bench for btn_debounce_pulser using a
//                streak/phase reference model and directed + random stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_debounce_pulser;

  localparam int D  = 4;
  localparam int H  = 10;
  localparam int R  = 3;
  localparam int CW = 8;

  localparam int P_IDLE  = 0;
  localparam int P_PULSE = 1;
  localparam int P_HELD  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       db_level;
  logic       scen;
  logic       mcen;
  logic [2:0] state;

  btn_debounce_pulser #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R),
    .CNT_W          (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .db_level(db_level),
    .scen    (scen),
    .mcen    (mcen),
    .state   (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // Reference model: button history expressed as streaks of equal samples.
  int m_phase;
  bit m_s1, m_bs, m_mflag;
  int m_ones;   // consecutive pressed samples while not yet accepted
  int m_t;      // consecutive pressed samples since the hold timer (re)started
  int m_z;      // consecutive released samples while held

  // Event logs for timing checks.
  int scen_log[$];
  int mcen_log[$];
  int fall_log[$];
  int hi_cnt;
  bit saw_rb;
  logic [2:0] prev_state;
  logic       prev_level;

  function automatic void m_reset();
    m_phase = P_IDLE;
    m_s1 = 0; m_bs = 0; m_mflag = 0;
    m_ones = 0; m_t = 0; m_z = 0;
  endfunction

  function automatic bit is_repeat_point(int t);
    return (t == H) || (t > H && ((t - H) % (R + 1)) == 0);
  endfunction

  function automatic void m_edge(bit b);
    bit bs;
    bs = m_bs;
    m_bs = m_s1;
    m_s1 = b;
    m_mflag = 0;
    case (m_phase)
      P_IDLE: begin
        if (bs) begin
          m_ones++;
          if (m_ones == D + 1) begin m_phase = P_PULSE; m_ones = 0; end
        end else m_ones = 0;
      end
      P_PULSE: begin m_phase = P_HELD; m_t = 0; m_z = 0; end
      default: begin
        if (bs) begin
          if (m_z > 0) begin m_t = 0; m_z = 0; end
          else begin
            m_t++;
            if (is_repeat_point(m_t)) m_mflag = 1;
          end
        end else begin
          m_z++;
          if (m_z == D + 1) begin m_phase = P_IDLE; m_ones = 0; m_z = 0; m_t = 0; end
        end
      end
    endcase
  endfunction

  function automatic logic [2:0] m_state();
    if (m_phase == P_IDLE)  return (m_ones == 0) ? 3'b000 : 3'b001;
    if (m_phase == P_PULSE) return 3'b010;
    if (m_z > 0)            return 3'b101;
    return (m_t >= H) ? 3'b100 : 3'b011;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    scen_log.delete(); mcen_log.delete(); fall_log.delete();
    hi_cnt = 0; saw_rb = 0;
  endtask

  // One clock: drive, let the edge happen, advance the model, check at negedge.
  task automatic cyc(input bit b);
    int e_scen;
    btn_in = b;
    @(posedge clk);
    m_edge(b);
    @(negedge clk);
    e_scen = (m_phase == P_PULSE) ? 1 : 0;
    chk("db_level", int'(db_level), (m_phase != P_IDLE) ? 1 : 0);
    chk("scen",     int'(scen),     e_scen);
    chk("mcen",     int'(mcen),     (e_scen != 0 || m_mflag) ? 1 : 0);
    chk("state",    int'(state),    int'(m_state()));
    if (scen) scen_log.push_back(cyc_n);
    if (mcen) mcen_log.push_back(cyc_n);
    if (prev_level && !db_level) fall_log.push_back(cyc_n);
    if (db_level) hi_cnt++;
    if (prev_state == 3'b101 && state == 3'b011) saw_rb = 1;
    prev_state = state;
    prev_level = db_level;
    cyc_n++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_db_level"}, int'(db_level), 0);
    chk({tag, "_scen"},     int'(scen),     0);
    chk({tag, "_mcen"},     int'(mcen),     0);
    chk({tag, "_state"},    int'(state),    0);
  endtask

  initial begin
    int base, rel, len, off;
    bit lvl, ok;
    rst = 1'b1;
    btn_in = 1'b0;
    prev_state = 3'b000;
    prev_level = 1'b0;
    m_reset();
    clear_logs();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Clean press: 8 cycles pressed, then released.
    repeat (3) cyc(0);
    clear_logs();
    base = cyc_n;
    repeat (8) cyc(1);
    rel = cyc_n;
    repeat (12) cyc(0);
    chk("clean_scen_count", scen_log.size(), 1);
    chk("clean_scen_latency", (scen_log.size() > 0) ? scen_log[0] - base : -1, D + 2);
    chk("clean_mcen_count", mcen_log.size(), 1);
    chk("clean_release_latency", (fall_log.size() > 0) ? fall_log[0] - rel : -1, D + 2);

    // Bounce rejection.
    clear_logs();
    cyc(1); cyc(0); cyc(1); cyc(1); cyc(0);
    repeat (8) cyc(0);
    chk("bounce_scen_count", scen_log.size(), 0);
    chk("bounce_mcen_count", mcen_log.size(), 0);
    chk("bounce_level_high", hi_cnt, 0);
    chk("bounce_final_state", int'(state), 0);

    // Auto-repeat: held 40 cycles.
    clear_logs();
    repeat (40) cyc(1);
    repeat (12) cyc(0);
    chk("repeat_scen_count", scen_log.size(), 1);
    chk("repeat_mcen_count", mcen_log.size(), 8);
    ok = 1;
    foreach (mcen_log[i]) begin
      off = mcen_log[i] - ((scen_log.size() > 0) ? scen_log[0] : 0);
      if (!(off == 0 || off == H + 1 || (off > H + 1 && ((off - H - 1) % (R + 1)) == 0)))
        ok = 0;
    end
    chk("repeat_mcen_spacing", int'(ok), 1);

    // Release bounce: 12 pressed, 2 released, back to pressed.
    clear_logs();
    repeat (12) cyc(1);
    cyc(0); cyc(0);
    repeat (4) cyc(1);
    repeat (12) cyc(0);
    chk("relbounce_seen_101_011", int'(saw_rb), 1);
    chk("relbounce_scen_count", scen_log.size(), 1);
    chk("relbounce_level_falls", fall_log.size(), 1);

    // Release sampled exactly when HOLD would hit terminal count.
    clear_logs();
    repeat (15) cyc(1);
    repeat (12) cyc(0);
    chk("relterm_mcen_count", mcen_log.size(), 1);

    // Reset in REPEAT with the button still held.
    repeat (25) cyc(1);
    chk("pre_reset_state", int'(state), 4);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    m_reset();
    @(negedge clk);
    check_reset_outputs("held_reset");
    prev_state = 3'b000;
    prev_level = 1'b0;
    rst = 1'b0;
    clear_logs();
    base = cyc_n;
    repeat (10) cyc(1);
    chk("post_reset_scen_count", scen_log.size(), 1);
    chk("post_reset_scen_latency", (scen_log.size() > 0) ? scen_log[0] - base : -1, D + 2);
    repeat (12) cyc(0);

    // Random runs and glitches against the reference model.
    lvl = 0;
    for (int s = 0; s < 120; s++) begin
      lvl = ~lvl;
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, D);
      else len = $urandom_range(1, H + 4 * (R + 1));
      repeat (len) cyc(lvl);
    end
    repeat (12) cyc(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
